// File: rtl/ctx_stat_rmw_ctrl_pkg.sv
// Shared definitions for the context-statistics read-modify-write scheduler.
package ctx_stat_rmw_ctrl_pkg;

    localparam int NUM_CTX = 365;
    localparam int AW      = 9;
    localparam int CTX_W   = 32;
    localparam int CNT_W   = 3;
    localparam logic [CTX_W-1:0] INIT_WORD = 32'h0000_0401;

    // Field placement inside a packed statistics word.
    localparam int N_LSB = 0;
    localparam int N_W   = 8;
    localparam int A_LSB = 8;
    localparam int A_W   = 8;
    localparam int B_LSB = 16;
    localparam int B_W   = 8;
    localparam int C_LSB = 24;
    localparam int C_W   = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ctx_stat_rmw_ctrl_infl_fifo.sv
// In-flight context FIFO: head at slot 0, shifts on pop, parallel compare
// against a probe index (head excluded while it is being popped).
module ctx_stat_rmw_ctrl_infl_fifo
    import ctx_stat_rmw_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = AW,
    parameter int CW    = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_q,
    input  logic          pop,
    input  logic [W-1:0]  cmp_q,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head,
    output logic          match
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] wr_idx;
    logic          pop_ok;
    logic          push_ok;

    always_comb begin
        pop_ok  = pop && (cnt_q != '0);
        push_ok = push && (pop_ok || (cnt_q < DEPTH_C));
        wr_idx  = pop_ok ? (cnt_q - CW'(1)) : cnt_q;

        mem_d = mem_q;
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && (CW'(i) == wr_idx)) begin
                mem_d[i] = push_q;
            end
        end

        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt_q) && (mem_q[i] == cmp_q) && !(pop && (i == 0))) begin
                match = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[0];

endmodule

// File: rtl/ctx_stat_rmw_ctrl.sv
// Read-modify-write scheduler owning the single port of the context-statistics RAM.
// Optional CTX_BYPASS_EN: accept a read of the context being written back in the same cycle.
//
// state   | meaning
// ST_INIT | writing INIT_WORD to every entry, requests blocked
// ST_RUN  | write-backs and reads share the port, write-back first
module ctx_stat_rmw_ctrl
    import ctx_stat_rmw_ctrl_pkg::*;
#(
    parameter int MAX_INFL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_in,
    input  logic [AW-1:0]    Q_in,
    output logic             ready,
    output logic             init_done,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [CTX_W-1:0] ram_wdata,
    input  logic [CTX_W-1:0] ram_rdata,
    output logic             ctx_valid,
    output logic [AW-1:0]    ctx_Q,
    output logic [CTX_W-1:0] ctx_stat,
    input  logic             upd_valid,
    input  logic [AW-1:0]    upd_Q,
    input  logic [CTX_W-1:0] upd_stat,
    output logic             err
);

    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_INFL);
    localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_CTX - 1);

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     init_cnt_q;
    logic              init_done_q;

    logic              run;
    logic              hazard;
    logic              ready_rd;
    logic              ready_byp;
    logic              accept;
    logic              byp_take;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [AW-1:0]     fifo_head;
    logic              err_set;

    logic              s1_valid_q;
    logic              s1_byp_q;
    logic [AW-1:0]     s1_q_q;
    logic [CTX_W-1:0]  s1_stat_q;
    logic              ctx_valid_q;
    logic [AW-1:0]     ctx_q_q;
    logic [CTX_W-1:0]  ctx_stat_q;
    logic              err_q;

    ctx_stat_rmw_ctrl_infl_fifo #(
        .DEPTH (MAX_INFL),
        .W     (AW),
        .CW    (CNT_W)
    ) u_infl_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (accept),
        .push_q (Q_in),
        .pop    (fifo_pop),
        .cmp_q  (Q_in),
        .count  (fifo_cnt),
        .head   (fifo_head),
        .match  (hazard)
    );

    always_comb begin
        run      = (state_q == ST_RUN);
        fifo_pop = upd_valid && run;
        ready_rd = init_done_q && !upd_valid && (fifo_cnt < MAX_C) && !hazard;
    end

`ifdef CTX_BYPASS_EN
    logic [CNT_W-1:0] cnt_after_pop;

    // The head is excluded from the hazard probe while it is popped, so a
    // request for the write-back context only clashes with a second copy.
    always_comb begin
        cnt_after_pop = (fifo_cnt == '0) ? '0 : (fifo_cnt - CNT_W'(1));
        ready_byp     = init_done_q && upd_valid && en_in && (Q_in == upd_Q) &&
                        !hazard && (cnt_after_pop < MAX_C);
    end
`else
    always_comb begin
        ready_byp = 1'b0;
    end
`endif

    always_comb begin
        ready    = ready_rd || ready_byp;
        accept   = en_in && ready;
        byp_take = accept && upd_valid;
        err_set  = upd_valid && (!run || (fifo_cnt == '0) || (upd_Q != fifo_head));
    end

    always_comb begin
        state_d   = state_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            ST_INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = init_cnt_q;
                ram_wdata = INIT_WORD;
                if (init_cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (upd_valid) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = upd_Q;
                    ram_wdata = upd_stat;
                end else if (accept) begin
                    ram_en   = 1'b1;
                    ram_addr = Q_in;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + AW'(1);
                if (init_cnt_q == LAST_IDX) begin
                    init_done_q <= 1'b1;
                end
            end
        end
    end

    // Stage 1 waits for the synchronous RAM read; a bypassed request carries
    // the write-back word instead and ignores ram_rdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_byp_q    <= 1'b0;
            s1_q_q      <= '0;
            s1_stat_q   <= '0;
            ctx_valid_q <= 1'b0;
            ctx_q_q     <= '0;
            ctx_stat_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= accept;
            s1_byp_q    <= byp_take;
            if (accept) begin
                s1_q_q    <= Q_in;
                s1_stat_q <= upd_stat;
            end
            ctx_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                ctx_q_q    <= s1_q_q;
                ctx_stat_q <= s1_byp_q ? s1_stat_q : ram_rdata;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign init_done = init_done_q;
    assign ctx_valid = ctx_valid_q;
    assign ctx_Q     = ctx_q_q;
    assign ctx_stat  = ctx_stat_q;
    assign err       = err_q;

endmodule

// File: doc/ctx_stat_rmw_ctrl.md
Name: ctx_stat_rmw_ctrl

Overview:
Read-modify-write scheduler for the context-statistics RAM. The RAM holds one packed {A,B,C,N} word per context.
- Accepts context indices Q from the context quantisation stage and issues RAM reads.
- Delivers the fetched statistics to the prediction-error/update stage and writes the updated words back.
- Initialises the RAM after reset and stalls the upstream stage on read-after-write hazards on the same context.
- Owns the single RAM port.

Parameters:
NUM_CTX, 365, number of contexts; RAM depth
CTX_W, 32, width of a packed statistics word
AW, 9, context index / RAM address width
MAX_INFL, 2, maximum contexts read but not yet written back (1..4)
INIT_WORD, 32'h0000_0401, value written to every entry during init (N=1, A=4, B=C=0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
en_in  in  1  request valid from context stage
Q_in  in  AW  requested context index
ready  out  1  request accepted when en_in&&ready; combinational
init_done  out  1  high once RAM init completes
ram_en  out  1  RAM port enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  CTX_W  RAM write data
ram_rdata  in  CTX_W  RAM read data, valid 1 cycle after read
ctx_valid  out  1  statistics valid pulse to update stage
ctx_Q  out  AW  context index of ctx_stat
ctx_stat  out  CTX_W  fetched statistics
upd_valid  in  1  updated word valid; always accepted
upd_Q  in  AW  context index of update
upd_stat  in  CTX_W  updated statistics
err  out  1  sticky protocol error

Behaviour:
- Reset (async, reset=0): state=INIT, init counter=0, in-flight FIFO empty. All registered outputs 0: init_done, ctx_valid, ctx_Q, ctx_stat, err. ready=0.
- INIT: each cycle ram_en=1, ram_we=1, ram_addr=counter, ram_wdata=INIT_WORD. Counter runs 0..NUM_CTX-1, then state=RUN and init_done=1 from the next cycle. Exactly NUM_CTX write cycles. en_in and upd_valid are ignored; upd_valid during INIT sets err.
- RAM port priority in RUN: write-back over read.
- Write-back:
  - When upd_valid=1, the same cycle drives ram_en=ram_we=1, ram_addr=upd_Q, ram_wdata=upd_stat, and pops the FIFO head.
  - upd_valid with an empty FIFO sets err; the write is still performed.
  - upd_Q differing from the FIFO head Q sets err; the write is still performed at upd_Q.
- Hazard: Q_in equals any FIFO entry's Q.
- ready = init_done & !upd_valid & (count<MAX_INFL) & !hazard.
- Read on accept at cycle t:
  - ram_en=1, ram_we=0, ram_addr=Q_in; Q_in is pushed into the FIFO.
  - ram_rdata is sampled at t+1.
  - ctx_valid=1 with ctx_Q and ctx_stat registered at t+2, for one cycle; ctx_valid is 0 otherwise.
  - Back-to-back accepts give back-to-back ctx_valid.
- An entry stays in-flight from its accept cycle through its write-back cycle. A read of that Q is accepted at write-back cycle +1 at the earliest and returns the written data.
- Push and pop in the same cycle cannot occur without CTX_BYPASS_EN, because ready=0 whenever upd_valid=1.
- An asynchronous reset mid-operation discards in-flight entries and pending ctx_valid, and re-runs the full INIT.

Optional Feature:
CTX_BYPASS_EN.
- With: when upd_valid=1 & en_in=1 & Q_in==upd_Q & no other FIFO entry matches & (count-1)<MAX_INFL, ready=1. The request is accepted in the same cycle as the write-back, with no RAM read. The FIFO pops the head and pushes Q_in. upd_stat is registered and presented as ctx_stat with ctx_valid at t+2. All other cases behave as without the macro.
- Without: ready=0 whenever upd_valid=1.

Decomposition:
- Shared package holds:
  - localparams NUM_CTX, AW, CTX_W, INIT_WORD
  - field offsets of A, B, C, N within the statistics word
  - state encoding ST_INIT/ST_RUN
- Sub-module infl_fifo (depth MAX_INFL, AW wide):
  - push/pop/count/head
  - parallel match output against a compare input, excluding the head when pop is asserted

Test Plan:
- Release reset -> exactly 365 write cycles, addr 0..364, wdata 32'h00000401; init_done rises on cycle 366; ready=0 throughout.
- After init, accept Q=5 at t with RAM[5]=X -> ram_addr=5 read at t; ctx_valid with ctx_Q=5, ctx_stat=X at t+2.
- Accept Q=5, then request Q=5 again before write-back -> ready=0 until the upd_valid(Q=5, S) cycle; accepted at the next cycle; returns S.
- Accept Q=3 and Q=7 back-to-back (MAX_INFL=2) -> third request Q=9 stalls until the first upd_valid; the write of Q=3 takes the port and ready=0 in that cycle.
- upd_valid with empty FIFO, or upd_Q=8 while the head is 3 -> err=1 and stays set; the write is still issued at addr 8.
- With CTX_BYPASS_EN: upd_valid(Q=5, S) with en_in Q=5 in the same cycle -> accepted; no RAM read; ctx_stat=S at t+2. Assert reset mid-run -> ctx_valid=0 immediately, and INIT repeats.
